// File: rtl/sequence_collector.sv
// Tail of the search sequence stream: counts candidates and hits, buffers hit
// sequences in a first-word-fall-through FIFO and reports when all hits have been read.
module sequence_collector #(
  parameter int SEQ_WIDTH = 8,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SEQ_WIDTH-1:0] i_seq,
  input  logic                 i_valid,
  input  logic                 i_done,
  input  logic                 i_match,
  output logic [SEQ_WIDTH-1:0] o_hit_seq,
  output logic                 o_hit_valid,
  input  logic                 i_hit_ready,
  output logic [CNT_WIDTH-1:0] o_cand_count,
  output logic [CNT_WIDTH-1:0] o_hit_count,
  output logic [CNT_WIDTH-1:0] o_drop_count,
  output logic                 o_overflow,
  output logic                 o_busy,
  output logic                 o_finished
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_OCC  = (AW+1)'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    DRAIN    = 2'd2,
    FINISHED = 2'd3
  } state_t;

  state_t state, state_next;

  logic [SEQ_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic [AW:0]          occupancy;
  logic                 empty, full;
  logic                 cand, hit, pop, push, drop;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // The extra pointer bit distinguishes full from empty when the indices match.
  assign occupancy = wr_ptr - rd_ptr;
  assign empty     = (occupancy == '0);
  assign full      = (occupancy == FULL_OCC);

  assign cand = i_valid & ~i_done & ((state == IDLE) | (state == RUN));
  assign hit  = cand & i_match;
  assign pop  = ~empty & i_hit_ready;
  assign push = hit & (~full | pop);
  assign drop = hit & full & ~pop;

  assign o_hit_valid = ~empty;
  assign o_hit_seq   = mem[rd_ptr[AW-1:0]];
  assign o_busy      = (state == RUN) | (state == DRAIN);
  assign o_finished  = (state == FINISHED);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (i_done) state_next = DRAIN;
                else if (cand) state_next = RUN;
      RUN:      if (i_done) state_next = DRAIN;
      DRAIN:    if (empty || (occupancy == ONE_OCC && pop)) state_next = FINISHED;
      FINISHED: state_next = FINISHED;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_cand_count <= '0;
      o_hit_count  <= '0;
      o_drop_count <= '0;
      o_overflow   <= 1'b0;
    end else begin
      state <= state_next;
      if (push) wr_ptr <= wr_ptr + ONE_OCC;
      if (pop)  rd_ptr <= rd_ptr + ONE_OCC;
      if (cand) o_cand_count <= sat_inc(o_cand_count);
      if (hit)  o_hit_count  <= sat_inc(o_hit_count);
      if (drop) begin
        o_drop_count <= sat_inc(o_drop_count);
        o_overflow   <= 1'b1;
      end
    end
  end

  // NOTE: the storage array has no reset; entries are only observable once the
  // pointers say they were written, so resetting them would add logic for nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= i_seq;
  end

endmodule

// File: tb/tb_sequence_collector.sv
// Directed bench for sequence_collector: default instance for stream, FIFO and
// FSM behaviour; a 4-bit-counter instance for saturation.
module tb_sequence_collector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: default parameters
  logic       rst, valid, done, match, ready;
  logic [7:0] seq;
  logic [7:0] hit_seq;
  logic       hit_valid, overflow, busy, finished;
  logic [15:0] cand_cnt, hit_cnt, drop_cnt;

  sequence_collector dut_a (
    .clk(clk), .rst(rst), .i_seq(seq), .i_valid(valid), .i_done(done),
    .i_match(match), .o_hit_seq(hit_seq), .o_hit_valid(hit_valid),
    .i_hit_ready(ready), .o_cand_count(cand_cnt), .o_hit_count(hit_cnt),
    .o_drop_count(drop_cnt), .o_overflow(overflow), .o_busy(busy),
    .o_finished(finished)
  );

  // Instance B: 4-bit saturating counters
  logic       b_rst, b_valid, b_done, b_match, b_ready;
  logic [7:0] b_seq, b_hit_seq;
  logic       b_hit_valid, b_overflow, b_busy, b_finished;
  logic [3:0] b_cand_cnt, b_hit_cnt, b_drop_cnt;

  sequence_collector #(.CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst(b_rst), .i_seq(b_seq), .i_valid(b_valid), .i_done(b_done),
    .i_match(b_match), .o_hit_seq(b_hit_seq), .o_hit_valid(b_hit_valid),
    .i_hit_ready(b_ready), .o_cand_count(b_cand_cnt), .o_hit_count(b_hit_cnt),
    .o_drop_count(b_drop_cnt), .o_overflow(b_overflow), .o_busy(b_busy),
    .o_finished(b_finished)
  );

  logic [7:0] got_a[$];
  logic [7:0] got_b[$];

  always @(posedge clk) begin
    if (!rst && hit_valid && ready) got_a.push_back(hit_seq);
    if (!b_rst && b_hit_valid && b_ready) got_b.push_back(b_hit_seq);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_expect(input logic [7:0] exp);
    check("pop_valid", 32'(hit_valid), 1);
    check("pop_seq", 32'(hit_seq), 32'(exp));
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  task automatic reset_a();
    rst = 1'b1; valid = 1'b0; done = 1'b0; match = 1'b0; ready = 1'b0; seq = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    b_rst = 1'b1; b_valid = 1'b0; b_done = 1'b0; b_match = 1'b0; b_ready = 1'b0; b_seq = '0;
    reset_a();
    tick();
    b_rst = 1'b0;

    // Reset state
    check("rst_cand", 32'(cand_cnt), 0);
    check("rst_hit", 32'(hit_cnt), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    check("rst_hit_valid", 32'(hit_valid), 0);
    check("rst_flags", {29'd0, overflow, busy, finished}, 0);

    // T1: stream 0..63 with hits on 5, 17, 63; final value repeated with done
    got_a.delete();
    ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      seq = 8'(i); valid = 1'b1; match = (i == 5 || i == 17 || i == 63);
      tick();
      if (i == 0) check("t1_busy_first", 32'(busy), 1);
    end
    seq = 8'd63; done = 1'b1; match = 1'b1;
    tick();
    valid = 1'b0; match = 1'b0;
    for (int i = 0; i < 20 && !finished; i++) tick();
    check("t1_finished", 32'(finished), 1);
    check("t1_cand", 32'(cand_cnt), 64);
    check("t1_hit", 32'(hit_cnt), 3);
    check("t1_drop", 32'(drop_cnt), 0);
    check("t1_nread", got_a.size(), 3);
    if (got_a.size() == 3) begin
      check("t1_read0", 32'(got_a[0]), 5);
      check("t1_read1", 32'(got_a[1]), 17);
      check("t1_read2", 32'(got_a[2]), 63);
    end

    // T2: six hits into a 4-deep FIFO with the reader stalled
    reset_a();
    for (int i = 10; i < 16; i++) begin
      seq = 8'(i); valid = 1'b1; match = 1'b1;
      tick();
    end
    valid = 1'b0; match = 1'b0;
    check("t2_hit", 32'(hit_cnt), 6);
    check("t2_drop", 32'(drop_cnt), 2);
    check("t2_overflow", 32'(overflow), 1);
    check("t2_head", 32'(hit_seq), 10);

    // T3: full FIFO, push and pop in the same cycle
    seq = 8'd20; valid = 1'b1; match = 1'b1; ready = 1'b1;
    tick();
    valid = 1'b0; match = 1'b0; ready = 1'b0;
    check("t3_drop", 32'(drop_cnt), 2);
    check("t3_hit", 32'(hit_cnt), 7);
    pop_expect(8'd11);
    pop_expect(8'd12);
    pop_expect(8'd13);
    pop_expect(8'd20);
    check("t3_empty", 32'(hit_valid), 0);

    // T4: end of stream with three hits buffered
    for (int i = 30; i < 33; i++) begin
      seq = 8'(i); valid = 1'b1; match = 1'b1;
      tick();
    end
    valid = 1'b0; match = 1'b0; done = 1'b1;
    tick();
    check("t4_busy", 32'(busy), 1);
    check("t4_not_finished", 32'(finished), 0);
    seq = 8'd99; valid = 1'b1; match = 1'b1; done = 1'b0;
    pop_expect(8'd30);
    pop_expect(8'd31);
    check("t4_finished_early", 32'(finished), 0);
    pop_expect(8'd32);
    check("t4_finished", 32'(finished), 1);
    check("t4_busy_off", 32'(busy), 0);
    tick(); tick(); tick();
    check("t4_cand_frozen", 32'(cand_cnt), 10);
    check("t4_hit_frozen", 32'(hit_cnt), 10);
    check("t4_drop_frozen", 32'(drop_cnt), 2);
    check("t4_still_finished", 32'(finished), 1);
    check("t4_fifo_empty", 32'(hit_valid), 0);

    // T5: reset in the middle of a run
    reset_a();
    for (int i = 40; i < 42; i++) begin
      seq = 8'(i); valid = 1'b1; match = 1'b1;
      tick();
    end
    check("t5_busy", 32'(busy), 1);
    rst = 1'b1; seq = 8'd42;
    tick();
    rst = 1'b0; valid = 1'b0; match = 1'b0;
    check("t5_cand", 32'(cand_cnt), 0);
    check("t5_hit", 32'(hit_cnt), 0);
    check("t5_hit_valid", 32'(hit_valid), 0);
    check("t5_idle", {30'd0, busy, finished}, 0);
    seq = 8'd50; valid = 1'b1; match = 1'b1;
    #1;
    check("t5_no_bypass", 32'(hit_valid), 0);
    tick();
    valid = 1'b0; match = 1'b0;
    check("t5_new_cand", 32'(cand_cnt), 1);
    check("t5_new_hit", 32'(hit_cnt), 1);
    check("t5_new_valid", 32'(hit_valid), 1);
    check("t5_new_seq", 32'(hit_seq), 50);

    // T6: counter saturation on the narrow-counter instance
    got_b.delete();
    b_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      b_seq = 8'(100 + i); b_valid = 1'b1; b_match = 1'b1;
      tick();
    end
    b_valid = 1'b0; b_match = 1'b0; b_done = 1'b1;
    for (int i = 0; i < 20 && !b_finished; i++) tick();
    check("t6_finished", 32'(b_finished), 1);
    check("t6_cand_sat", 32'(b_cand_cnt), 15);
    check("t6_hit_sat", 32'(b_hit_cnt), 15);
    check("t6_drop", 32'(b_drop_cnt), 0);
    check("t6_nread", got_b.size(), 20);
    for (int i = 0; i < got_b.size() && i < 20; i++)
      check("t6_read", 32'(got_b[i]), 32'(100 + i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
